// File: rtl/sketch_pkg.sv
// Shared definitions for the etch-a-sketch blocks: screen geometry,
// colour width and the pixel plotter state encoding.
package sketch_pkg;

   localparam int X_MAX   = 160;
   localparam int Y_MAX   = 120;
   localparam int COLOR_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLOT  = 2'd1,
      CLEAR = 2'd2
   } plot_state_t;

endpackage

// File: rtl/pixel_plotter_if.sv
// Cursor inputs and VGA plot port of the pixel plotter, bundled as one
// interface. The master side supplies the cursor, the slave side (the
// plotter) owns every vga_* signal plus the clear status.
interface pixel_plotter_if #(
   parameter int COLOR_W = sketch_pkg::COLOR_W
);

   logic [7:0]         xpos;
   logic [7:0]         ypos;
   logic               pen_down;
   logic [COLOR_W-1:0] pen_color;
   logic               clear_req;

   logic [7:0]         vga_x;
   logic [6:0]         vga_y;
   logic [COLOR_W-1:0] vga_color;
   logic               vga_plot;
   logic               busy;
   logic               clear_done;

   modport master (
      output xpos, ypos, pen_down, pen_color, clear_req,
      input  vga_x, vga_y, vga_color, vga_plot, busy, clear_done
   );

   modport slave (
      input  xpos, ypos, pen_down, pen_color, clear_req,
      output vga_x, vga_y, vga_color, vga_plot, busy, clear_done
   );

endinterface

// File: rtl/pixel_plotter_screen_sweeper.sv
// Raster counters for full-screen operations: x runs 0..X_MAX-1 as the
// inner loop, y runs 0..Y_MAX-1 as the outer loop. 'last' flags the final
// pixel of the frame so the owner can stop without an extra compare.
module screen_sweeper #(
   parameter int X_MAX = sketch_pkg::X_MAX,
   parameter int Y_MAX = sketch_pkg::Y_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       step,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       last
);

   localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
   localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);

   // Raster counter: start rewinds to the origin, step advances one pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x <= '0;
         y <= '0;
      end else if (start) begin
         x <= '0;
         y <= '0;
      end else if (step) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 7'd1;
         end else begin
            x <= x + 8'd1;
         end
      end
   end

   assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/pixel_plotter.sv
// Pixel plotter: turns cursor movement into single-pixel writes on the
// VGA adapter plot port and runs a full-screen clear sweep on request.
module pixel_plotter
   import sketch_pkg::plot_state_t, sketch_pkg::IDLE, sketch_pkg::PLOT, sketch_pkg::CLEAR;
#(
   parameter int                 X_MAX    = sketch_pkg::X_MAX,
   parameter int                 Y_MAX    = sketch_pkg::Y_MAX,
   parameter int                 COLOR_W  = sketch_pkg::COLOR_W,
   parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
   input  logic            clk,
   input  logic            reset,
   pixel_plotter_if.slave  bus
);

   localparam logic [7:0] X_LIM = 8'(X_MAX);
   localparam logic [7:0] Y_LIM = 8'(Y_MAX);

   plot_state_t        state_q, state_d;

   logic [7:0]         last_x_q;
   logic [7:0]         last_y_q;
   logic               replot_q;

   logic [7:0]         plot_x_q;
   logic [6:0]         plot_y_q;
   logic [COLOR_W-1:0] plot_color_q;

   logic               plot_q;
   logic               busy_q;
   logic               done_q;

   logic               sw_start;
   logic               sw_step;
   logic               sw_last;
   logic [7:0]         sw_x;
   logic [6:0]         sw_y;

   logic               cursor_hit;
   logic               load_cursor;
   logic               plot_d;
   logic               done_d;

   // A cursor plot is due when the pen is down, the position is on screen
   // and it differs from what was last drawn (or a redraw was forced).
   assign cursor_hit = bus.pen_down
                    && (bus.xpos < X_LIM)
                    && (bus.ypos < Y_LIM)
                    && ((bus.xpos != last_x_q) || (bus.ypos != last_y_q) || replot_q);

   screen_sweeper #(
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX)
   ) u_sweeper (
      .clk   (clk),
      .reset (reset),
      .start (sw_start),
      .step  (sw_step),
      .x     (sw_x),
      .y     (sw_y),
      .last  (sw_last)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-cycle control; a clear request outranks a cursor plot.
   always_comb begin
      state_d     = state_q;
      sw_start    = 1'b0;
      sw_step     = 1'b0;
      load_cursor = 1'b0;
      plot_d      = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.clear_req) begin
               state_d  = CLEAR;
               sw_start = 1'b1;
               plot_d   = 1'b1;
            end else if (cursor_hit) begin
               state_d     = PLOT;
               load_cursor = 1'b1;
               plot_d      = 1'b1;
            end
         end
         PLOT: begin
            state_d = IDLE;
         end
         CLEAR: begin
            if (sw_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               sw_step = 1'b1;
               plot_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Cursor bookkeeping: remember what was drawn, force a redraw after a clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_x_q     <= '0;
         last_y_q     <= '0;
         replot_q     <= 1'b1;
         plot_x_q     <= '0;
         plot_y_q     <= '0;
         plot_color_q <= '0;
      end else if (load_cursor) begin
         last_x_q     <= bus.xpos;
         last_y_q     <= bus.ypos;
         replot_q     <= 1'b0;
         plot_x_q     <= bus.xpos;
         plot_y_q     <= bus.ypos[6:0];
         plot_color_q <= bus.pen_color;
      end else if (done_d) begin
         replot_q <= 1'b1;
      end
   end

   // Registered strobes and status toward the VGA adapter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         plot_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         plot_q <= plot_d;
         busy_q <= (state_d == CLEAR);
         done_q <= done_d;
      end
   end

   // Coordinates come from the sweeper counters while clearing and from the
   // cursor registers otherwise; both sources and the select are flops, so
   // the values hold for the whole strobe cycle.
   assign bus.vga_x      = busy_q ? sw_x     : plot_x_q;
   assign bus.vga_y      = busy_q ? sw_y     : plot_y_q;
   assign bus.vga_color  = busy_q ? BG_COLOR : plot_color_q;
   assign bus.vga_plot   = plot_q;
   assign bus.busy       = busy_q;
   assign bus.clear_done = done_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Bench for pixel_plotter: directed vector table, clear and reset corner
// sequences, then randomized cursor traffic against a behavioural model.
module tb_pixel_plotter;

   localparam int         XM = 160;
   localparam int         YM = 120;
   localparam int         CW = 3;
   localparam logic [2:0] BG = 3'b110;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pixel_plotter_if #(.COLOR_W(CW)) bus ();

   pixel_plotter #(
      .X_MAX    (XM),
      .Y_MAX    (YM),
      .COLOR_W  (CW),
      .BG_COLOR (BG)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int plot_count;

   // Behavioural model: last drawn position, forced-redraw flag, a one-cycle
   // gap after each cursor plot, and a linear pixel index while clearing.
   int m_lx, m_ly, m_clr;
   bit m_rep, m_gap;
   bit e_plot, e_busy, e_done;
   int e_x, e_y, e_col;

   typedef struct {
      int x; int y; bit pen; int col; bit clr;
      bit e_plot; int e_x; int e_y; int e_col;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(int x, int y, bit pen, int col, bit clr,
                              bit ep, int ex, int ey, int ec);
      vec_t r;
      r.x = x; r.y = y; r.pen = pen; r.col = col; r.clr = clr;
      r.e_plot = ep; r.e_x = ex; r.e_y = ey; r.e_col = ec;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int x, input int y, input bit pen, input int col, input bit clr);
      bus.xpos      = 8'(x);
      bus.ypos      = 8'(y);
      bus.pen_down  = pen;
      bus.pen_color = CW'(col);
      bus.clear_req = clr;
   endtask

   task automatic model_reset();
      m_lx = 0; m_ly = 0; m_rep = 1'b1; m_gap = 1'b0; m_clr = -1;
   endtask

   task automatic model_step();
      int x, y;
      x = int'(bus.xpos);
      y = int'(bus.ypos);
      e_plot = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (m_clr >= 0) begin
         m_clr++;
         if (m_clr == XM * YM) begin
            e_done = 1'b1; m_rep = 1'b1; m_clr = -1;
         end else begin
            e_plot = 1'b1; e_busy = 1'b1;
            e_x = m_clr % XM; e_y = m_clr / XM; e_col = int'(BG);
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (bus.clear_req) begin
         m_clr = 0; e_plot = 1'b1; e_busy = 1'b1;
         e_x = 0; e_y = 0; e_col = int'(BG);
      end else if (bus.pen_down && x < XM && y < YM && (x != m_lx || y != m_ly || m_rep)) begin
         e_plot = 1'b1; e_x = x; e_y = y; e_col = int'(bus.pen_color);
         m_lx = x; m_ly = y; m_rep = 1'b0; m_gap = 1'b1;
      end
   endtask

   // One clock: the model consumes the inputs present at the edge, then the
   // DUT outputs are compared just after it.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("plot", bus.vga_plot, e_plot);
      check("busy", bus.busy, e_busy);
      check("clear_done", bus.clear_done, e_done);
      if (e_plot) begin
         check("vga_x", bus.vga_x, e_x);
         check("vga_y", bus.vga_y, e_y);
         check("vga_color", bus.vga_color, e_col);
      end
      if (bus.vga_plot === 1'b1) plot_count++;
   endtask

   initial begin
      int lx, ly;
      bit started;

      // Reset state
      reset = 1'b1;
      drive(5, 7, 1'b1, 5, 1'b0);
      #2 reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_plot", bus.vga_plot, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.clear_done, 0);
      check("rst_x", bus.vga_x, 0);
      check("rst_y", bus.vga_y, 0);
      check("rst_color", bus.vga_color, 0);
      @(negedge clk) reset = 1'b1;

      // Directed vector table
      tbl.push_back(v(  5,   7, 1, 5, 0, 1,   5,   7, 5));
      tbl.push_back(v(  5,   7, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(  5,   7, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(  5,   7, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(  6,   7, 1, 5, 0, 1,   6,   7, 5));
      tbl.push_back(v(  7,   7, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(  7,   7, 1, 5, 0, 1,   7,   7, 5));
      tbl.push_back(v(  7,   7, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(160,   7, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(160,   7, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(159,   7, 1, 5, 0, 1, 159,   7, 5));
      tbl.push_back(v(159, 120, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(159, 120, 1, 5, 0, 0,   0,   0, 0));
      tbl.push_back(v(159, 119, 1, 2, 0, 1, 159, 119, 2));
      tbl.push_back(v( 10,  10, 0, 3, 0, 0,   0,   0, 0));
      tbl.push_back(v( 15,  15, 0, 3, 0, 0,   0,   0, 0));
      tbl.push_back(v( 20,  20, 0, 3, 0, 0,   0,   0, 0));
      tbl.push_back(v( 20,  20, 1, 3, 0, 1,  20,  20, 3));
      tbl.push_back(v( 20,  20, 1, 3, 0, 0,   0,   0, 0));
      tbl.push_back(v( 20,  20, 0, 3, 0, 0,   0,   0, 0));
      tbl.push_back(v( 20,  20, 1, 3, 0, 0,   0,   0, 0));
      tbl.push_back(v( 20,  20, 1, 3, 0, 0,   0,   0, 0));

      plot_count = 0;
      foreach (tbl[i]) begin
         drive(tbl[i].x, tbl[i].y, tbl[i].pen, tbl[i].col, tbl[i].clr);
         tick();
         check($sformatf("tbl%0d_plot", i), bus.vga_plot, tbl[i].e_plot);
         if (tbl[i].e_plot) begin
            check($sformatf("tbl%0d_x", i), bus.vga_x, tbl[i].e_x);
            check($sformatf("tbl%0d_y", i), bus.vga_y, tbl[i].e_y);
            check($sformatf("tbl%0d_color", i), bus.vga_color, tbl[i].e_col);
         end
      end
      check("tbl_plot_count", plot_count, 6);

      // Clear requested in the same cycle as a cursor move
      plot_count = 0;
      drive(30, 40, 1'b1, 4, 1'b1);
      tick();
      check("clr_first_x", bus.vga_x, 0);
      check("clr_first_y", bus.vga_y, 0);
      check("clr_first_busy", bus.busy, 1);
      drive(30, 40, 1'b1, 4, 1'b0);
      lx = -1; ly = -1;
      for (int i = 1; i < XM * YM; i++) begin
         tick();
         if (bus.vga_plot === 1'b1) begin
            lx = int'(bus.vga_x);
            ly = int'(bus.vga_y);
         end
      end
      check("clr_count", plot_count, XM * YM);
      check("clr_last_x", lx, XM - 1);
      check("clr_last_y", ly, YM - 1);
      tick();
      check("clr_done_pulse", bus.clear_done, 1);
      check("clr_done_busy", bus.busy, 0);
      check("clr_done_noplot", bus.vga_plot, 0);
      tick();
      check("clr_replot", bus.vga_plot, 1);
      check("clr_replot_x", bus.vga_x, 30);
      check("clr_replot_y", bus.vga_y, 40);
      tick();
      check("clr_done_once", bus.clear_done, 0);

      // Reset in the middle of a sweep
      drive(30, 40, 1'b1, 4, 1'b1);
      tick();
      drive(30, 40, 1'b1, 4, 1'b0);
      repeat (999) tick();
      #3 reset = 1'b0;
      #1;
      check("arst_plot", bus.vga_plot, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_x", bus.vga_x, 0);
      check("arst_y", bus.vga_y, 0);
      check("arst_color", bus.vga_color, 0);
      model_reset();
      repeat (2) begin
         @(posedge clk);
         #1;
         check("arst_hold_plot", bus.vga_plot, 0);
         check("arst_hold_done", bus.clear_done, 0);
      end
      @(negedge clk) reset = 1'b1;
      tick();
      check("arst_replot", bus.vga_plot, 1);
      check("arst_replot_x", bus.vga_x, 30);
      check("arst_replot_y", bus.vga_y, 40);
      check("arst_replot_color", bus.vga_color, 4);

      // Randomized traffic with at most one clear (ignored pulses during it)
      started = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         drive(($urandom_range(0, 4) == 0) ? $urandom_range(157, 163) : $urandom_range(0, 3),
               ($urandom_range(0, 4) == 0) ? $urandom_range(117, 123) : $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, $urandom_range(0, 7),
               ($urandom_range(0, 149) == 0) && (!started || m_clr >= 0));
         tick();
         if (m_clr >= 0) started = 1'b1;
      end
      for (int k = 0; k < XM * YM + 10 && m_clr >= 0; k++) begin
         drive($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 1) != 0,
               $urandom_range(0, 7), $urandom_range(0, 49) == 0);
         tick();
      end
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
               $urandom_range(0, 7), 1'b0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
